// File: rtl/wb_arb_pkg.sv
// Shared types and limits for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE -> BUSY -> [TERM] -> IDLE)
//   N_MST_MAX   : largest supported master count
package wb_arb_pkg;

  localparam int N_MST_MAX = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_TERM
  } arb_state_t;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per master
//   ptr   : master with highest priority this round
//   pick  : one-hot winner (first requester scanning ptr, ptr+1, ... mod N)
//   valid : at least one request present
module wb_arb_rr_pick import wb_arb_pkg::*; #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic found;

  // Walk offsets from ptr; for each offset exactly one master j satisfies
  // (j - o) mod N == ptr. Keeps every bit index constant.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int o = 0; o < N; o++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (int'(ptr) == ((j - o + N) % N))) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_MST masters share one slave-side bus.
// A grant is held for the whole cyc of the winner; every grant change passes
// through at least one IDLE cycle with s_cyc low.
//   clk, rst                  : clock, synchronous active-high reset
//   m_cyc/m_stb/m_we          : per-master strobes
//   m_adr/m_dat_o/m_sel       : per-master request fields, master i at [i*W +: W]
//   m_ack/m_err               : per-master responses (only the granted master)
//   m_dat_i                   : slave read data broadcast to all masters
//   s_cyc/s_stb/s_we/s_adr/s_dat_o/s_sel : slave-side request
//   s_ack/s_err/s_dat_i       : slave response
//   gnt                       : registered one-hot grant
// Optional: WB_ARB_TIMEOUT_EN adds a stall counter; after TIMEOUT_CYC stalled
// cycles the transfer is killed with a one-cycle m_err (TERM state).
module wb_rr_arbiter import wb_arb_pkg::*; #(
  parameter int N_MST       = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        m_cyc,
  input  logic [N_MST-1:0]        m_stb,
  input  logic [N_MST-1:0]        m_we,
  input  logic [N_MST*AW-1:0]     m_adr,
  input  logic [N_MST*DW-1:0]     m_dat_o,
  input  logic [N_MST*DW/8-1:0]   m_sel,
  output logic [N_MST-1:0]        m_ack,
  output logic [N_MST-1:0]        m_err,
  output logic [DW-1:0]           m_dat_i,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [AW-1:0]           s_adr,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic [DW-1:0]           s_dat_i,
  output logic [N_MST-1:0]        gnt
);

  localparam int SW = DW / 8;
  localparam int PW = $clog2(N_MST);

  if (N_MST < 2 || N_MST > N_MST_MAX) begin : g_bad_n
    $error("wb_rr_arbiter: N_MST must be 2..%0d", N_MST_MAX);
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_to
    $error("wb_rr_arbiter: TIMEOUT_CYC must be >= 1");
  end

  arb_state_t       state;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [N_MST-1:0] pick;
  logic             pick_vld;
  logic             g_cyc, g_stb;
  logic             busy, term, to_hit;

  wb_arb_rr_pick #(.N(N_MST)) u_pick (
    .req   (m_cyc),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  // AND-OR mux on the one-hot grant; all zero while nothing is granted.
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    ptr_nxt = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (gnt[i]) begin
        g_cyc   = m_cyc[i];
        g_stb   = m_stb[i];
        s_we    = m_we[i];
        s_adr   = m_adr[i*AW +: AW];
        s_dat_o = m_dat_o[i*DW +: DW];
        s_sel   = m_sel[i*SW +: SW];
        ptr_nxt = PW'((i + 1) % N_MST);
      end
    end
  end

  assign busy    = (state == ARB_BUSY);
  assign term    = (state == ARB_TERM);
  assign s_cyc   = busy & g_cyc;
  assign s_stb   = busy & g_stb;
  // Responses outside BUSY (spurious or during TERM) never reach a master.
  assign m_ack   = busy ? (gnt & {N_MST{s_ack}}) : '0;
  assign m_err   = term ? gnt : (busy ? (gnt & {N_MST{s_err}}) : '0);
  assign m_dat_i = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] stall_cnt;

  // Counts cycles the granted strobe sits unanswered; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || !busy || !s_stb || s_ack || s_err)
      stall_cnt <= '0;
    else if (stall_cnt != CW'(TIMEOUT_CYC))
      stall_cnt <= stall_cnt + CW'(1);
  end

  assign to_hit = (stall_cnt == CW'(TIMEOUT_CYC));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            gnt   <= pick;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Master release wins over a simultaneous timeout.
          if (!g_cyc) begin
            gnt   <= '0;
            ptr   <= ptr_nxt;
            state <= ARB_IDLE;
          end else if (to_hit) begin
            state <= ARB_TERM;
          end
        end
        ARB_TERM: begin
          gnt   <= '0;
          ptr   <= ptr_nxt;
          state <= ARB_IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios followed by random traffic, all
// checked against an ownership-level reference model running every cycle.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0]   m_adr = '0;
  logic [N*DW-1:0]   m_dat_o = '0;
  logic [N*SW-1:0]   m_sel = '0;
  logic [N-1:0]      m_ack, m_err, gnt;
  logic [DW-1:0]     m_dat_i;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel;
  logic              s_ack = 1'b0, s_err = 1'b0;
  logic [DW-1:0]     s_dat_i = '0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_o(m_dat_o), .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err),
    .m_dat_i(m_dat_i), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel), .s_ack(s_ack),
    .s_err(s_err), .s_dat_i(s_dat_i), .gnt(gnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bt(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Reference model: who owns the bus, whose turn is next, whether the owner
  // is in its forced-error cycle, and how long its strobe has been stalled.
  int owner   = -1;
  int mptr    = 0;
  int stall   = 0;
  bit in_term = 1'b0;
  bit mdl_ok  = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      owner = -1; mptr = 0; stall = 0; in_term = 1'b0; mdl_ok = 1'b1;
    end else if (owner < 0) begin
      for (int o = 0; o < N; o++)
        if (owner < 0 && bt(m_cyc, (mptr + o) % N)) owner = (mptr + o) % N;
      stall = 0;
    end else if (in_term || !bt(m_cyc, owner)) begin
      mptr = (owner + 1) % N; owner = -1; in_term = 1'b0; stall = 0;
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      if (stall == TO) in_term = 1'b1;
      if (!bt(m_stb, owner) || s_ack || s_err) stall = 0;
      else if (stall < TO) stall++;
`endif
    end
  end

  logic [N-1:0] eg;
  bit           mbusy;

  initial forever begin
    @(negedge clk);
    if (mdl_ok) begin
      eg = '0;
      if (owner >= 0) eg = N'(1) << owner;
      mbusy = (owner >= 0) && !in_term;
      chk("gnt",     64'(gnt),   64'(eg));
      chk("s_cyc",   64'(s_cyc), 64'(mbusy && bt(m_cyc, owner)));
      chk("s_stb",   64'(s_stb), 64'(mbusy && bt(m_stb, owner)));
      chk("m_ack",   64'(m_ack), 64'((mbusy && s_ack) ? eg : '0));
      chk("m_err",   64'(m_err), 64'(in_term ? eg : ((mbusy && s_err) ? eg : '0)));
      chk("m_dat_i", 64'(m_dat_i), 64'(s_dat_i));
      if (mbusy) begin
        chk("s_adr",   64'(s_adr),   64'(AW'(m_adr >> (owner * AW))));
        chk("s_dat_o", 64'(s_dat_o), 64'(DW'(m_dat_o >> (owner * DW))));
        chk("s_sel",   64'(s_sel),   64'(SW'(m_sel >> (owner * SW))));
        chk("s_we",    64'(s_we),    64'(bt(m_we, owner)));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic rst_pulse;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int acks, k, bad;

  initial begin
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_gnt",  64'(gnt),   64'(0));
    chk("rst_scyc", 64'(s_cyc), 64'(0));
    chk("rst_merr", 64'(m_err), 64'(0));

    // 1: lone m0 request, slave acks two cycles after grant
    m_adr = {32'h0000_0020, 32'h9900_0004};
    m_cyc = 2'b01; m_stb = 2'b01;
    #1 chk("t1_pre_gnt", 64'(gnt), 64'(0));
    step(); #1;
    chk("t1_gnt",  64'(gnt),   64'(2'b01));
    chk("t1_scyc", 64'(s_cyc), 64'(1));
    chk("t1_adr",  64'(s_adr), 64'(32'h9900_0004));
    step(); step();
    s_ack = 1'b1;
    #1 chk("t1_ack", 64'(m_ack), 64'(2'b01));
    step();
    s_ack = 1'b0; idle_all();
    #1 chk("t1_ack_off", 64'(m_ack), 64'(0));
    step(); #1 chk("t1_release", 64'(gnt), 64'(0));

    // 2: simultaneous requests after reset, m0 first, then m1 via one IDLE cycle
    rst_pulse();
    m_cyc = 2'b11; m_stb = 2'b11;
    step(); #1 chk("t2_first", 64'(gnt), 64'(2'b01));
    m_cyc = 2'b10; m_stb = 2'b10;
    step(); #1;
    chk("t2_idle_gnt",  64'(gnt),   64'(0));
    chk("t2_idle_scyc", 64'(s_cyc), 64'(0));
    step(); #1 chk("t2_second", 64'(gnt), 64'(2'b10));

    // 3: m1 4-beat burst, m0 waiting; no preemption
    m_cyc = 2'b11; m_stb = 2'b11;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      s_ack = (i % 2 == 1);
      #1;
      acks += int'(m_ack[1]);
      chk("t3_hold", 64'(gnt), 64'(2'b10));
      chk("t3_ack0", 64'(m_ack[0]), 64'(0));
      step();
    end
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
    chk("t3_beats", 64'(acks), 64'(4));
    step(); #1 chk("t3_idle", 64'(gnt), 64'(0));
    step(); #1 chk("t3_m0", 64'(gnt), 64'(2'b01));

    // 4: reset while m1 holds the bus with stb high
    m_cyc = 2'b10; m_stb = 2'b10;
    step(); step(); #1 chk("t4_m1", 64'(gnt), 64'(2'b10));
    rst = 1'b1;
    step(); #1;
    chk("t4_rst_gnt",  64'(gnt),   64'(0));
    chk("t4_rst_scyc", 64'(s_cyc), 64'(0));
    rst = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
    step(); #1 chk("t4_after", 64'(gnt), 64'(2'b01));
    idle_all();
    step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // 5: slave never answers m0; forced error then m1 gets the bus
    rst_pulse();
    m_cyc = 2'b11; m_stb = 2'b01;
    step(); #1 chk("t5_gnt", 64'(gnt), 64'(2'b01));
    k = 0;
    while (!m_err[0] && k < 40) begin
      step(); #1;
      k++;
    end
    chk("t5_lat",  64'(k),     64'(17));
    chk("t5_scyc", 64'(s_cyc), 64'(0));
    step(); #1;
    chk("t5_pulse", 64'(m_err), 64'(0));
    chk("t5_idle",  64'(gnt),   64'(0));
    step(); #1 chk("t5_m1", 64'(gnt), 64'(2'b10));
    idle_all();
    step(); step();
`else
    // 6: long stall holds the grant, no error, ack still delivered
    rst_pulse();
    m_cyc = 2'b11; m_stb = 2'b01;
    step(); #1 chk("t6_gnt", 64'(gnt), 64'(2'b01));
    bad = 0;
    repeat (299) begin
      step(); #1;
      if (m_err != '0 || gnt != 2'b01 || m_ack != '0) bad++;
    end
    chk("t6_stall", 64'(bad), 64'(0));
    step();
    s_ack = 1'b1;
    #1 chk("t6_ack", 64'(m_ack), 64'(2'b01));
    step();
    idle_all();
    step(); step();
`endif

    // Random traffic; the model checks every cycle.
    repeat (3000) begin
      step();
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) m_cyc = m_cyc ^ N'(1 << i);
      m_stb   = m_cyc & N'($urandom);
      m_we    = N'($urandom);
      m_adr   = {$urandom, $urandom};
      m_dat_o = {$urandom, $urandom};
      m_sel   = N*SW'($urandom);
      s_ack   = ($urandom_range(3) == 0);
      s_err   = ($urandom_range(15) == 0);
      s_dat_i = $urandom;
      rst     = ($urandom_range(99) == 0);
    end
    rst = 1'b0;
    idle_all();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

endmodule
